cp0: RTL and testbench

CP0 -- requirements
Module: cp0

---
 rtl/cp0_pkg.sv | 14 +
 rtl/cp0_sync.sv | 16 +
 rtl/cp0.sv | 68 ++++++
 tb/tb_cp0.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, SR/Cause field positions and the PRId value.
package cp0_pkg;
   localparam logic [4:0]  SEL_SR    = 5'd12;
   localparam logic [4:0]  SEL_CAUSE = 5'd13;
   localparam logic [4:0]  SEL_EPC   = 5'd14;
   localparam logic [4:0]  SEL_PRID  = 5'd15;
   localparam int          IM_HI     = 15;
   localparam int          IM_LO     = 10;
   localparam int          IP_HI     = 15;
   localparam int          IP_LO     = 10;
   localparam int          EXL_BIT   = 1;
   localparam int          IE_BIT    = 0;
   localparam logic [31:0] PRID_VAL  = 32'h0000_3000;
endpackage

// File: rtl/cp0_sync.sv
// cp0_sync: parameterized-width two-flop synchronizer with sync reset to 0.
module cp0_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] s1_q, s2_q;
   always_ff @(posedge clk) begin
      s1_q <= rst ? '0 : d_i;
      s2_q <= rst ? '0 : s1_q;
   end
   assign q_o = s2_q;
endmodule

// File: rtl/cp0.sv
// cp0: SR/Cause/EPC/PRId coprocessor with interrupt request generation.
// CP0_IRQ_SYNC_EN adds a two-flop synchronizer in front of the interrupt lines.
module cp0
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] pc,
   input  logic [31:0] din,
   input  logic [4:0]  sel,
   input  logic        wen,
   input  logic        exl_set,
   input  logic        exl_clr,
   input  logic [5:0]  hwint,
   output logic        intreq,
   output logic [29:0] epc,
   output logic [31:0] dout
);
   logic [5:0]  hw_s;
   logic [5:0]  ip_q, im_q, im_d;
   logic        exl_q, exl_d, ie_q, ie_d;
   logic [29:0] epc_q, epc_d;
   logic        sr_we, epc_we;
`ifdef CP0_IRQ_SYNC_EN
   cp0_sync #(.W(6)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (hwint),
      .q_o (hw_s)
   );
`else
   assign hw_s = hwint;
`endif
   assign sr_we  = wen && (sel == SEL_SR);
   assign epc_we = wen && (sel == SEL_EPC);
   // exl_set wins over both the SR write and eret so handler entry is never lost
   always_comb begin
      im_d  = sr_we ? din[IM_HI:IM_LO] : im_q;
      ie_d  = sr_we ? din[IE_BIT] : ie_q;
      exl_d = exl_set ? 1'b1 : sr_we ? din[EXL_BIT] : exl_clr ? 1'b0 : exl_q;
      epc_d = exl_set ? pc : epc_we ? din[31:2] : epc_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ip_q  <= '0;
         im_q  <= '0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         epc_q <= '0;
      end else begin
         ip_q  <= hw_s;
         im_q  <= im_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         epc_q <= epc_d;
      end
   end
   assign intreq = |(ip_q & im_q) & ie_q & ~exl_q & ~rst;
   assign epc    = epc_q;
   always_comb begin
      dout = '0;
      dout[IM_HI:IM_LO] = (sel == SEL_SR) ? im_q : '0;
      dout[IP_HI:IP_LO] = (sel == SEL_CAUSE) ? ip_q : dout[IP_HI:IP_LO];
      dout[EXL_BIT] = (sel == SEL_SR) & exl_q;
      dout[IE_BIT] = (sel == SEL_SR) & ie_q;
      dout = (sel == SEL_EPC) ? {epc_q, 2'b00} : (sel == SEL_PRID) ? PRID_VAL : dout;
   end
endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed self-checking bench for cp0 (either CP0_IRQ_SYNC_EN build).
module tb_cp0;
`ifdef CP0_IRQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   logic        clk = 0, rst = 0, wen = 0, exl_set = 0, exl_clr = 0;
   logic [29:0] pc = '0;
   logic [31:0] din = '0;
   logic [4:0]  sel = '0;
   logic [5:0]  hwint = '0;
   logic        intreq;
   logic [29:0] epc;
   logic [31:0] dout;
   int tests = 0, fails = 0;

   cp0 dut (
      .clk(clk), .rst(rst), .pc(pc), .din(din), .sel(sel), .wen(wen),
      .exl_set(exl_set), .exl_clr(exl_clr), .hwint(hwint),
      .intreq(intreq), .epc(epc), .dout(dout)
   );

   always #10 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] s, output logic [31:0] v);
      sel = s;
      #1;
      v = dout;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst = 1;
      step(2);
      tests++;
      if (intreq !== 1'b0) begin fails++; $display("FAIL rst_intreq got %b want 0", intreq); end
      rst = 0;
      step();
      rd(5'd12, v); tests++;
      if (v !== 32'h0) begin fails++; $display("FAIL rst_sr got %h want 00000000", v); end
      rd(5'd13, v); tests++;
      if (v !== 32'h0) begin fails++; $display("FAIL rst_cause got %h want 00000000", v); end
      rd(5'd14, v); tests++;
      if (v !== 32'h0) begin fails++; $display("FAIL rst_epc got %h want 00000000", v); end
      rd(5'd15, v); tests++;
      if (v !== 32'h0000_3000) begin fails++; $display("FAIL prid got %h want 00003000", v); end
      rd(5'd7, v); tests++;
      if (v !== 32'h0) begin fails++; $display("FAIL unmapped got %h want 00000000", v); end
   endtask

   task automatic test_irq();
      logic [31:0] v;
      wen = 1; sel = 5'd12; din = 32'h0000_0401;
      step();
      wen = 0;
      rd(5'd12, v); tests++;
      if (v !== 32'h0000_0401) begin fails++; $display("FAIL sr_wr got %h want 00000401", v); end
      hwint = 6'b000001;
      #1; tests++;
      if (intreq !== 1'b0) begin fails++; $display("FAIL irq_early got %b want 0", intreq); end
      step(LAT); tests++;
      if (intreq !== 1'b1) begin fails++; $display("FAIL irq_on got %b want 1", intreq); end
      rd(5'd13, v); tests++;
      if (v !== 32'h0000_0400) begin fails++; $display("FAIL cause_ip0 got %h want 00000400", v); end
      hwint = 6'b000010;
      step(LAT); tests++;
      if (intreq !== 1'b0) begin fails++; $display("FAIL irq_masked got %b want 0", intreq); end
      rd(5'd13, v); tests++;
      if (v !== 32'h0000_0800) begin fails++; $display("FAIL cause_ip1 got %h want 00000800", v); end
   endtask

   task automatic test_exl();
      logic [31:0] v;
      hwint = 6'b000001;
      step(LAT); tests++;
      if (intreq !== 1'b1) begin fails++; $display("FAIL exl_pre got %b want 1", intreq); end
      pc = 30'h0000_0C10; exl_set = 1;
      step();
      exl_set = 0; tests++;
      if (epc !== 30'h0000_0C10) begin fails++; $display("FAIL exl_epc got %h want 00000c10", epc); end
      rd(5'd12, v); tests++;
      if (v !== 32'h0000_0403) begin fails++; $display("FAIL exl_sr got %h want 00000403", v); end
      rd(5'd14, v); tests++;
      if (v !== 32'h0000_3040) begin fails++; $display("FAIL exl_epcrd got %h want 00003040", v); end
      tests++;
      if (intreq !== 1'b0) begin fails++; $display("FAIL exl_intreq got %b want 0", intreq); end
      exl_clr = 1;
      step();
      exl_clr = 0;
      rd(5'd12, v); tests++;
      if (v !== 32'h0000_0401) begin fails++; $display("FAIL eret_sr got %h want 00000401", v); end
      tests++;
      if (intreq !== 1'b1) begin fails++; $display("FAIL eret_intreq got %b want 1", intreq); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      pc = 30'h0000_0111; exl_set = 1; exl_clr = 1;
      step();
      exl_set = 0; exl_clr = 0;
      rd(5'd12, v); tests++;
      if (v !== 32'h0000_0403) begin fails++; $display("FAIL setclr_sr got %h want 00000403", v); end
      tests++;
      if (epc !== 30'h0000_0111) begin fails++; $display("FAIL setclr_epc got %h want 00000111", epc); end
      exl_clr = 1;
      step();
      exl_clr = 0;
      pc = 30'h0000_0123; exl_set = 1; wen = 1; sel = 5'd12; din = 32'h0;
      step();
      exl_set = 0; wen = 0;
      rd(5'd12, v); tests++;
      if (v !== 32'h0000_0002) begin fails++; $display("FAIL set_srwr got %h want 00000002", v); end
      tests++;
      if (epc !== 30'h0000_0123) begin fails++; $display("FAIL sync_exc_epc got %h want 00000123", epc); end
      pc = 30'h0000_0222; exl_set = 1; wen = 1; sel = 5'd14; din = 32'hFFFF_FFFC;
      step();
      exl_set = 0; wen = 0; tests++;
      if (epc !== 30'h0000_0222) begin fails++; $display("FAIL set_epcwr got %h want 00000222", epc); end
   endtask

   task automatic test_epc_write();
      logic [31:0] v;
      wen = 1; sel = 5'd14; din = 32'h0000_3007;
      step();
      wen = 0;
      rd(5'd14, v); tests++;
      if (v !== 32'h0000_3004) begin fails++; $display("FAIL epc_wr got %h want 00003004", v); end
      hwint = 6'b000001;
      step(LAT);
      wen = 1; sel = 5'd13; din = 32'hFFFF_FFFF;
      step();
      wen = 0;
      rd(5'd13, v); tests++;
      if (v !== 32'h0000_0400) begin fails++; $display("FAIL cause_wr got %h want 00000400", v); end
      wen = 1; sel = 5'd15;
      step();
      wen = 0;
      rd(5'd15, v); tests++;
      if (v !== 32'h0000_3000) begin fails++; $display("FAIL prid_wr got %h want 00003000", v); end
      rd(5'd12, v); tests++;
      if (v !== 32'h0000_0002) begin fails++; $display("FAIL sr_kept got %h want 00000002", v); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      wen = 1; sel = 5'd12; din = 32'h0000_0401;
      step();
      wen = 0; pc = 30'h0000_0555; exl_set = 1;
      step();
      exl_set = 0; tests++;
      if (epc !== 30'h0000_0555) begin fails++; $display("FAIL mid_epc got %h want 00000555", epc); end
      rst = 1; wen = 1; sel = 5'd12; din = 32'h0000_FC03; exl_set = 1; exl_clr = 1;
      #1; tests++;
      if (intreq !== 1'b0) begin fails++; $display("FAIL mid_rst_intreq got %b want 0", intreq); end
      step();
      rst = 0; wen = 0; exl_set = 0; exl_clr = 0;
      rd(5'd12, v); tests++;
      if (v !== 32'h0) begin fails++; $display("FAIL mid_sr got %h want 00000000", v); end
      rd(5'd13, v); tests++;
      if (v !== 32'h0) begin fails++; $display("FAIL mid_cause got %h want 00000000", v); end
      rd(5'd14, v); tests++;
      if (v !== 32'h0) begin fails++; $display("FAIL mid_epc_rd got %h want 00000000", v); end
      tests++;
      if (intreq !== 1'b0) begin fails++; $display("FAIL mid_intreq got %b want 0", intreq); end
   endtask

   initial begin
      test_reset();
      test_irq();
      test_exl();
      test_back_to_back();
      test_epc_write();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
